// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, limits and parity helpers
//
// Purpose: common definitions for the UART transmitter and its future RX
// counterpart.
// Contents:
//   DATA_BITS_MIN/MAX : legal payload width range
//   tx_state_e        : transmit frame states
//   parity_e          : parity selection encoding (2'b11 is treated as none)
//   parityEnabled()   : true for EVEN or ODD
//   parityBit()       : parity bit for a zero-padded word
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  function automatic logic parityEnabled(input logic [1:0] mode);
    return (mode == EVEN) || (mode == ODD);
  endfunction

  // Unused upper bits of the word must be zero so they do not disturb the XOR.
  function automatic logic parityBit(input logic [DATA_BITS_MAX-1:0] word,
                                     input logic [1:0]               mode);
    return (mode == ODD) ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter producing one tick per serial bit
//
// Purpose: times serial bits. The counter is loaded with (bit length - 1) and
// counts down; bitTick is asserted during the last clock of each bit, at which
// point the counter reloads for the next bit. The receiver loads a half-bit
// value first to land in mid-bit, then runs on full-bit reloads.
// Ports:
//   clk, resetN  : clock, asynchronous active-low reset
//   load         : restart the counter with loadValue (has priority over run)
//   loadValue    : value loaded on load
//   run          : counter advances while high
//   reloadValue  : value reloaded after each tick
//   bitTick      : last clock of the current bit
module uart_bit_timer #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [DIV_W-1:0] loadValue,
  input  logic             run,
  input  logic [DIV_W-1:0] reloadValue,
  output logic             bitTick
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (run) begin
      if (count == '0) begin
        count <= reloadValue;
      end else begin
        count <= count - DIV_W'(1);
      end
    end
  end

  assign bitTick = run && (count == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter (5..9 data bits, parity, 1/2 stop)
//
// Purpose: serialises one word per txDv/txReady handshake, LSB first, framed
// by a start bit, optional parity bit and one or two stop bits. Each bit lasts
// max(clocksPerBit,1) clocks. Word and configuration are captured at accept, so
// input changes during a frame only affect the next one.
// Parameters:
//   DATA_BITS : payload width, 5..9
//   DIV_W     : width of clocksPerBit and of the bit timer
// Ports:
//   clk, resetN  : clock, asynchronous active-low reset
//   txDv         : word valid; held by the producer until txReady
//   incomingByte : word to send
//   clocksPerBit : clocks per serial bit (0 and 1 both mean 1)
//   parityMode   : 00 none, 01 even, 10 odd, 11 none
//   twoStop      : 1 selects two stop bits
//   txReady      : high in IDLE; txDv && txReady accepts a word
//   txActive     : frame in progress (accept edge through last stop clock)
//   txDone       : one-cycle pulse on return to IDLE
//   txSerial     : serial line, idles high
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 32
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 txDv,
  input  logic [DATA_BITS-1:0] incomingByte,
  input  logic [DIV_W-1:0]     clocksPerBit,
  input  logic [1:0]           parityMode,
  input  logic                 twoStop,
  output logic                 txReady,
  output logic                 txActive,
  output logic                 txDone,
  output logic                 txSerial
);

  localparam int              CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_e state, stateNext;

  logic [CNT_W-1:0]         bitCounter, bitCounterNext;
  logic [DATA_BITS-1:0]     shiftReg, shiftNext;
  logic                     stopCount, stopCountNext;
  logic                     serialNext;
  logic                     doneNext;

  // Frame configuration captured at accept.
  logic [DIV_W-1:0]         bitLenM1;
  logic                     parityEn;
  logic                     parityVal;
  logic                     twoStopReg;

  logic                     accept;
  logic                     bitTick;
  logic [DIV_W-1:0]         acceptLenM1;
  logic [DATA_BITS_MAX-1:0] paddedWord;

  assign accept = txDv && txReady;

  // 0 and 1 both give a single-clock bit.
  assign acceptLenM1 = (clocksPerBit == '0) ? '0 : clocksPerBit - DIV_W'(1);

  always_comb begin
    paddedWord                  = '0;
    paddedWord[DATA_BITS-1:0]   = incomingByte;
  end

  // Loaded on accept so the start bit gets a full bit time from the next
  // cycle on; it only counts while a frame is in progress.
  uart_bit_timer #(
    .DIV_W(DIV_W)
  ) bitTimer (
    .clk        (clk),
    .resetN     (resetN),
    .load       (accept),
    .loadValue  (acceptLenM1),
    .run        (state != IDLE),
    .reloadValue(bitLenM1),
    .bitTick    (bitTick)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bitLenM1   <= '0;
      parityEn   <= 1'b0;
      parityVal  <= 1'b0;
      twoStopReg <= 1'b0;
    end else if (accept) begin
      bitLenM1   <= acceptLenM1;
      parityEn   <= parityEnabled(parityMode);
      parityVal  <= parityBit(paddedWord, parityMode);
      twoStopReg <= twoStop;
    end
  end

  // Next-state logic also computes the next line level, so every output comes
  // straight from a flop and changes exactly at the bit boundary.
  always_comb begin
    stateNext      = state;
    bitCounterNext = bitCounter;
    shiftNext      = shiftReg;
    stopCountNext  = stopCount;
    serialNext     = txSerial;
    doneNext       = 1'b0;

    case (state)
      IDLE: begin
        serialNext = 1'b1;
        if (accept) begin
          stateNext      = START;
          shiftNext      = incomingByte;
          bitCounterNext = '0;
          stopCountNext  = 1'b0;
          serialNext     = 1'b0;
        end
      end

      START: begin
        if (bitTick) begin
          stateNext  = DATA;
          serialNext = shiftReg[0];
        end
      end

      DATA: begin
        if (bitTick) begin
          bitCounterNext = bitCounter + CNT_W'(1);
          if (bitCounter == LAST_BIT) begin
            if (parityEn) begin
              stateNext  = PARITY;
              serialNext = parityVal;
            end else begin
              stateNext  = STOP;
              serialNext = 1'b1;
            end
          end else begin
            shiftNext  = shiftReg >> 1;
            serialNext = shiftReg[1];
          end
        end
      end

      PARITY: begin
        if (bitTick) begin
          stateNext  = STOP;
          serialNext = 1'b1;
        end
      end

      STOP: begin
        if (bitTick) begin
          if (twoStopReg && !stopCount) begin
            stopCountNext = 1'b1;
          end else begin
            stateNext  = IDLE;
            serialNext = 1'b1;
            doneNext   = 1'b1;
          end
        end
      end

      default: begin
        stateNext  = IDLE;
        serialNext = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      bitCounter <= '0;
      shiftReg   <= '0;
      stopCount  <= 1'b0;
      txSerial   <= 1'b1;
      txDone     <= 1'b0;
      txActive   <= 1'b0;
      txReady    <= 1'b1;
    end else begin
      state      <= stateNext;
      bitCounter <= bitCounterNext;
      shiftReg   <= shiftNext;
      stopCount  <= stopCountNext;
      txSerial   <= serialNext;
      txDone     <= doneNext;
      txActive   <= (stateNext != IDLE);
      txReady    <= (stateNext == IDLE);
    end
  end

endmodule
